// File: rtl/tl_ul_host_bridge_if.sv
// TL-UL bundle for 8-bit source, 32-bit address, 8-bit sink and 32-bit data.
// The producer modport is the initiator side. It drives the A channel and d_ready.
// The responder modport is the target side. It drives a_ready and the D channel.
interface TL_UL_8_32_8_32;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_corrupt;

    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [7:0]  d_source;
    logic [31:0] d_data;
    logic        d_error;

    modport producer (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        output d_ready,
        input  a_ready,
        input  d_valid, d_opcode, d_source, d_data, d_error
    );

    modport responder (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        input  d_ready,
        output a_ready,
        output d_valid, d_opcode, d_source, d_data, d_error
    );
endinterface

// File: rtl/tl_ul_host_bridge.sv
// TL-UL host bridge.
// Turns single-word commands on a valid/ready port into one TL-UL A-channel request.
// The request is a Get, a PutFullData or a PutPartialData.
// Only one transaction is outstanding at a time.
// The matching D beat is returned as a one-cycle response pulse.
//
// Ports
//   clk, rst_b                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_write                      1 = write, 0 = read
//   cmd_addr                       byte address
//   cmd_wdata, cmd_mask            write data and byte enables
//   rsp_valid                      one-cycle response pulse
//   rsp_rdata                      read data
//   rsp_error                      set for d_error, an opcode mismatch or a timeout
//   rsp_timeout                    set when the response was aborted by the timeout
//   stale_rsp                      one-cycle pulse when a D beat is discarded
//   busy                           a transaction is in flight
//   bus                            TL-UL producer port
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | ready for a command; any D beat is stale
// A_REQ   | A request presented, held until a_ready
// D_WAIT  | waiting for the D beat with the issued source, timer running
module tl_ul_host_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [7:0]  SOURCE_BASE    = 8'd0
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [31:0]             cmd_addr,
    input  logic [31:0]             cmd_wdata,
    input  logic [3:0]              cmd_mask,
    output logic                    rsp_valid,
    output logic [31:0]             rsp_rdata,
    output logic                    rsp_error,
    output logic                    rsp_timeout,
    output logic                    stale_rsp,
    output logic                    busy,
    TL_UL_8_32_8_32.producer        bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_A_REQ  = 2'd1,
        ST_D_WAIT = 2'd2
    } state_e;

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_ACK         = 3'd0;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES);

    state_e        state_q, state_d;
    logic          write_q, write_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    mask_q, mask_d;
    logic [7:0]    src_q, src_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_error_q, rsp_error_d;
    logic          rsp_timeout_q, rsp_timeout_d;
    logic          stale_q, stale_d;

    logic [7:0]    issued_src;
    logic          src_match;
    logic          a_active;
    logic [2:0]    a_opcode;

    // src_q has already advanced past the source of the outstanding request.
    assign issued_src = src_q - 8'd1;
    assign src_match  = bus.d_valid && (bus.d_source == issued_src);

    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        mask_d        = mask_q;
        src_d         = src_q;
        tmr_d         = tmr_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = 32'd0;
        rsp_error_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        stale_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                stale_d = bus.d_valid;
                if (cmd_valid) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr & 32'hFFFF_FFFC;
                    wdata_d = cmd_write ? cmd_wdata : 32'd0;
                    mask_d  = cmd_write ? cmd_mask : 4'hF;
                    state_d = ST_A_REQ;
                end
            end
            ST_A_REQ: begin
                stale_d = bus.d_valid;
                if (bus.a_ready) begin
                    src_d   = src_q + 8'd1;
                    tmr_d   = TMR_LOAD;
                    state_d = ST_D_WAIT;
                end
            end
            ST_D_WAIT: begin
                if (src_match) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = write_q ? 32'd0 : bus.d_data;
                    rsp_error_d = bus.d_error |
                                  (write_q ? (bus.d_opcode != OP_ACK) : (bus.d_opcode != OP_ACK_DATA));
                    state_d     = ST_IDLE;
                end else begin
                    stale_d = bus.d_valid;
                    // A matching beat on the last cycle is served above, so it beats the timeout.
                    if ((TIMEOUT_CYCLES != 0) && (tmr_q == TW'(1))) begin
                        rsp_valid_d   = 1'b1;
                        rsp_error_d   = 1'b1;
                        rsp_timeout_d = 1'b1;
                        state_d       = ST_IDLE;
                    end else begin
                        tmr_d = tmr_q - TW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q       <= ST_IDLE;
            write_q       <= 1'b0;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            mask_q        <= 4'd0;
            src_q         <= SOURCE_BASE;
            tmr_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'd0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            stale_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            write_q       <= write_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            mask_q        <= mask_d;
            src_q         <= src_d;
            tmr_q         <= tmr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
            stale_q       <= stale_d;
        end
    end

    // A-channel fields read as zero whenever no request is presented.
    assign a_active = (state_q == ST_A_REQ);
    assign a_opcode = !write_q ? OP_GET : ((mask_q == 4'hF) ? OP_PUT_FULL : OP_PUT_PARTIAL);

    assign bus.a_valid   = a_active;
    assign bus.a_opcode  = a_active ? a_opcode : 3'd0;
    assign bus.a_param   = 3'd0;
    assign bus.a_size    = a_active ? 2'd2 : 2'd0;
    assign bus.a_source  = a_active ? src_q : 8'd0;
    assign bus.a_address = a_active ? addr_q : 32'd0;
    assign bus.a_mask    = a_active ? mask_q : 4'd0;
    assign bus.a_data    = a_active ? wdata_q : 32'd0;
    assign bus.a_corrupt = 1'b0;
    assign bus.d_ready   = 1'b1;

    assign cmd_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_timeout = rsp_timeout_q;
    assign stale_rsp   = stale_q;

endmodule

// File: tb/tb_tl_ul_host_bridge.sv
module tb_tl_ul_host_bridge;
    localparam int         TMO  = 8;
    localparam logic [7:0] SRC0 = 8'd255;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_mask;
    logic        rsp_valid, rsp_error, rsp_timeout, stale_rsp, busy;
    logic [31:0] rsp_rdata;

    TL_UL_8_32_8_32 bus_if ();

    tl_ul_host_bridge #(.TIMEOUT_CYCLES(TMO), .SOURCE_BASE(SRC0)) dut (
        .clk(clk), .rst_b(rst_b),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .rsp_timeout(rsp_timeout), .stale_rsp(stale_rsp), .busy(busy),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] src_exp;

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          ardy_dly;
        int          d_dly;
        logic [2:0]  d_op;
        bit          d_err;
        logic [31:0] d_data;
        bit          wrong_src;
        bit          late_beat;
        logic [2:0]  exp_op;
        logic [3:0]  exp_mask;
        logic [31:0] exp_addr;
        logic [31:0] exp_adata;
        logic [31:0] exp_rdata;
        bit          exp_err;
        bit          exp_tmo;
    } vec_t;

    vec_t tbl[11];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check32(name, 32'(act), 32'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference rules: opcode/mask from the command kind, word-aligned address,
    // timeout when the beat would arrive after TMO waiting cycles.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        r           = v;
        r.exp_op    = !v.write ? 3'd4 : ((v.mask == 4'hF) ? 3'd0 : 3'd1);
        r.exp_mask  = v.write ? v.mask : 4'hF;
        r.exp_addr  = {v.addr[31:2], 2'b00};
        r.exp_adata = v.write ? v.wdata : 32'd0;
        r.exp_tmo   = (v.d_dly >= TMO);
        r.exp_rdata = (r.exp_tmo || v.write) ? 32'd0 : v.d_data;
        r.exp_err   = r.exp_tmo || v.d_err || (v.d_op != (v.write ? 3'd0 : 3'd1));
        return r;
    endfunction

    task automatic do_txn(input vec_t v);
        logic [7:0] src;
        bit beat, wrong;
        src = src_exp;
        check1("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_mask = v.mask;
        step();
        cmd_valid = 1'b0; cmd_write = ~v.write; cmd_addr = ~v.addr;
        cmd_wdata = ~v.wdata; cmd_mask = ~v.mask;
        for (int i = 0; i <= v.ardy_dly; i++) begin
            check1("a_valid", bus_if.a_valid, 1'b1);
            check32("a_opcode", 32'(bus_if.a_opcode), 32'(v.exp_op));
            check32("a_address", bus_if.a_address, v.exp_addr);
            check32("a_mask", 32'(bus_if.a_mask), 32'(v.exp_mask));
            check32("a_data", bus_if.a_data, v.exp_adata);
            check32("a_source", 32'(bus_if.a_source), 32'(src));
            check32("a_size", 32'(bus_if.a_size), 32'd2);
            check1("cmd_ready_areq", cmd_ready, 1'b0);
            bus_if.a_ready = (i == v.ardy_dly);
            step();
        end
        bus_if.a_ready = 1'b0;
        src_exp = src_exp + 8'd1;
        for (int c = 1; c <= TMO; c++) begin
            beat  = 1'b0;
            wrong = v.wrong_src && (c == 1) && (v.d_dly >= 1);
            if (wrong) begin
                bus_if.d_valid = 1'b1; bus_if.d_source = src + 8'd1;
                bus_if.d_opcode = v.d_op; bus_if.d_error = 1'b0; bus_if.d_data = 32'hBAD0_BAD0;
            end else if (c == v.d_dly + 1) begin
                beat = 1'b1;
                bus_if.d_valid = 1'b1; bus_if.d_source = src;
                bus_if.d_opcode = v.d_op; bus_if.d_error = v.d_err; bus_if.d_data = v.d_data;
            end
            check1("a_valid_dwait", bus_if.a_valid, 1'b0);
            check1("busy_dwait", busy, 1'b1);
            check1("rsp_valid_early", rsp_valid, 1'b0);
            step();
            bus_if.d_valid = 1'b0; bus_if.d_error = 1'b0;
            check1("stale_rsp_dwait", stale_rsp, wrong);
            if (beat || c == TMO) break;
        end
        check1("rsp_valid", rsp_valid, 1'b1);
        check32("rsp_rdata", rsp_rdata, v.exp_rdata);
        check1("rsp_error", rsp_error, v.exp_err);
        check1("rsp_timeout", rsp_timeout, v.exp_tmo);
        check1("cmd_ready_rsp", cmd_ready, 1'b1);
        check1("busy_rsp", busy, 1'b0);
        if (v.exp_tmo && v.late_beat) begin
            bus_if.d_valid = 1'b1; bus_if.d_source = src; bus_if.d_opcode = v.d_op;
            bus_if.d_data = v.d_data;
        end
        step();
        bus_if.d_valid = 1'b0;
        check1("rsp_valid_pulse", rsp_valid, 1'b0);
        check1("stale_late", stale_rsp, v.exp_tmo && v.late_beat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] issued;
        vec_t v;

        //             wr   addr           wdata          mask   ardy dly op    err   d_data         ws lb   e_op  e_mask e_addr         e_adata        e_rdata        e_err e_tmo
        tbl[0]  = '{1'b0, 32'h0000_0010, 32'h0BAD_F00D, 4'h0, 0, 1, 3'd1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 3'd4, 4'hF, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 32'h0000_0007, 32'h1234_5678, 4'hF, 5, 0, 3'd0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 3'd0, 4'hF, 32'h0000_0004, 32'h1234_5678, 32'h0,         1'b0, 1'b0};
        tbl[2]  = '{1'b1, 32'h0000_0007, 32'h1234_5678, 4'h3, 0, 2, 3'd0, 1'b0, 32'h0,         1'b0, 1'b0, 3'd1, 4'h3, 32'h0000_0004, 32'h1234_5678, 32'h0,         1'b0, 1'b0};
        tbl[3]  = '{1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'hF, 2, 0, 3'd1, 1'b0, 32'h1111_1111, 1'b0, 1'b0, 3'd0, 4'hF, 32'h0000_0020, 32'hCAFE_F00D, 32'h0,         1'b1, 1'b0};
        tbl[4]  = '{1'b0, 32'h0000_0044, 32'h0,         4'hF, 0, 8, 3'd1, 1'b0, 32'h0000_0077, 1'b0, 1'b1, 3'd4, 4'hF, 32'h0000_0044, 32'h0,         32'h0,         1'b1, 1'b1};
        tbl[5]  = '{1'b0, 32'h0000_0048, 32'h0,         4'hF, 1, 3, 3'd1, 1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0, 3'd4, 4'hF, 32'h0000_0048, 32'h0,         32'hA5A5_A5A5, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 32'h0000_004E, 32'h00FF_00FF, 4'h0, 0, 0, 3'd0, 1'b0, 32'h0,         1'b0, 1'b0, 3'd1, 4'h0, 32'h0000_004C, 32'h00FF_00FF, 32'h0,         1'b0, 1'b0};
        tbl[7]  = '{1'b0, 32'h0000_0100, 32'h0,         4'hF, 0, 7, 3'd1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 3'd4, 4'hF, 32'h0000_0100, 32'h0,         32'h0000_0001, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 32'h0000_0104, 32'h0,         4'hF, 0, 0, 3'd0, 1'b0, 32'h0000_0055, 1'b0, 1'b0, 3'd4, 4'hF, 32'h0000_0104, 32'h0,         32'h0000_0055, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 32'hFFFF_FFFF, 32'h0,         4'hF, 0, 0, 3'd1, 1'b0, 32'h1357_9BDF, 1'b0, 1'b0, 3'd4, 4'hF, 32'hFFFF_FFFC, 32'h0,         32'h1357_9BDF, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 32'h0000_0050, 32'h0,         4'hF, 0, 9, 3'd1, 1'b0, 32'h0000_0099, 1'b1, 1'b1, 3'd4, 4'hF, 32'h0000_0050, 32'h0,         32'h0,         1'b1, 1'b1};

        rst_b = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_wdata = 32'd0; cmd_mask = 4'd0;
        bus_if.a_ready = 1'b0; bus_if.d_valid = 1'b0; bus_if.d_opcode = 3'd0;
        bus_if.d_source = 8'd0; bus_if.d_data = 32'd0; bus_if.d_error = 1'b0;
        src_exp = SRC0;
        step(); step();
        check1("rst_cmd_ready", cmd_ready, 1'b1);
        check1("rst_a_valid", bus_if.a_valid, 1'b0);
        check32("rst_a_opcode", 32'(bus_if.a_opcode), 32'd0);
        check32("rst_a_source", 32'(bus_if.a_source), 32'd0);
        check32("rst_a_address", bus_if.a_address, 32'd0);
        check1("rst_d_ready", bus_if.d_ready, 1'b1);
        check1("rst_busy", busy, 1'b0);
        check1("rst_rsp_valid", rsp_valid, 1'b0);
        check1("rst_stale", stale_rsp, 1'b0);
        rst_b = 1'b1;
        step();

        // Stray beat while idle.
        bus_if.d_valid = 1'b1; bus_if.d_source = SRC0; bus_if.d_opcode = 3'd1;
        step();
        bus_if.d_valid = 1'b0;
        check1("stale_idle", stale_rsp, 1'b1);
        check1("rsp_valid_idle", rsp_valid, 1'b0);
        step();
        check1("stale_idle_pulse", stale_rsp, 1'b0);

        for (int i = 0; i < 11; i++) do_txn(tbl[i]);

        // Stray beat during A_REQ, then async reset while waiting for D.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h80; cmd_mask = 4'hF;
        step();
        cmd_valid = 1'b0;
        check1("seq_a_valid", bus_if.a_valid, 1'b1);
        bus_if.d_valid = 1'b1; bus_if.d_source = src_exp; bus_if.d_opcode = 3'd1;
        step();
        bus_if.d_valid = 1'b0;
        check1("stale_areq", stale_rsp, 1'b1);
        check1("seq_a_valid_held", bus_if.a_valid, 1'b1);
        bus_if.a_ready = 1'b1;
        step();
        bus_if.a_ready = 1'b0;
        issued  = src_exp;
        src_exp = src_exp + 8'd1;
        check1("seq_busy", busy, 1'b1);
        step();
        #2 rst_b = 1'b0;
        #1;
        check1("arst_a_valid", bus_if.a_valid, 1'b0);
        check1("arst_busy", busy, 1'b0);
        check1("arst_cmd_ready", cmd_ready, 1'b1);
        check1("arst_rsp_valid", rsp_valid, 1'b0);
        step();
        rst_b = 1'b1;
        src_exp = SRC0;
        bus_if.d_valid = 1'b1; bus_if.d_source = issued; bus_if.d_opcode = 3'd1;
        bus_if.d_data = 32'h4444_4444;
        step();
        bus_if.d_valid = 1'b0;
        check1("arst_stale", stale_rsp, 1'b1);
        check1("arst_no_rsp", rsp_valid, 1'b0);
        step();

        // Randomised transactions against the rule-level model.
        for (int n = 0; n < 40; n++) begin
            v.write     = 1'($urandom_range(0, 1));
            v.addr      = $urandom;
            v.wdata     = $urandom;
            v.mask      = 4'($urandom_range(0, 15));
            v.ardy_dly  = $urandom_range(0, 3);
            v.d_dly     = $urandom_range(0, 10);
            v.d_op      = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : (v.write ? 3'd0 : 3'd1);
            v.d_err     = ($urandom_range(0, 7) == 0);
            v.d_data    = $urandom;
            v.wrong_src = ($urandom_range(0, 3) == 0);
            v.late_beat = 1'($urandom_range(0, 1));
            do_txn(model(v));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
